bus_write_sequencer: RTL

- Write-side counterpart to the CPU's input data latches: accepts one byte plus address from the core and sequences a complete external-bus write cycle.
- Drives address, R/W and data-output-enable in defined phases: address setup, data drive, data hold.
- Sits between the core's write request path and the external address/data bus pins.
- Captured address and data are held internally for the whole cycle, so the core may change its inputs freely after acceptance.

---
 rtl/bus_write_sequencer_if.sv | 26 ++
 rtl/bus_write_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/bus_write_sequencer_if.sv
// Core-to-bus write interface: request/capture side plus external bus pins.
// The sequencer uses the slave modport; the requesting core uses master.
interface bus_write_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 16
);
  logic              wr_req;
  logic [AWIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ready;
  logic              done;
  logic [AWIDTH-1:0] addr_out;
  logic [WIDTH-1:0]  data_out;
  logic              data_oe;
  logic              rw;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ready, done, addr_out, data_out, data_oe, rw
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ready, done, addr_out, data_out, data_oe, rw
  );
endinterface

// File: rtl/bus_write_sequencer.sv
// Sequences one external-bus write: address setup, data drive, data hold.
// Address and data are captured on acceptance and held until the next write.
module bus_write_sequencer #(
  parameter int WIDTH        = 8,
  parameter int AWIDTH       = 16,
  parameter int ADDR_CYCLES  = 1,
  parameter int DRIVE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bus_write_sequencer_if.slave  bus
);

  if (ADDR_CYCLES < 1) begin : g_bad_addr_cycles
    $error("ADDR_CYCLES must be at least 1");
  end
  if (DRIVE_CYCLES < 1) begin : g_bad_drive_cycles
    $error("DRIVE_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES < 0) begin : g_bad_hold_cycles
    $error("HOLD_CYCLES must not be negative");
  end

  // Counter counts down from phase length minus one, so it never needs MAXC itself.
  localparam int          MAX_AD = (ADDR_CYCLES > DRIVE_CYCLES) ? ADDR_CYCLES : DRIVE_CYCLES;
  localparam int          MAXC   = (MAX_AD > HOLD_CYCLES) ? MAX_AD : HOLD_CYCLES;
  localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DRIVE,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          state_d = ADDR;
          cnt_d   = CW'(ADDR_CYCLES - 1);
          addr_d  = bus.wr_addr;
          data_d  = bus.wr_data;
        end
      end
      ADDR: begin
        if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = CW'(DRIVE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus controls decode from the state register only; wr_req never reaches an output.
  assign bus.wr_ready = (state_q == IDLE);
  assign bus.rw       = !((state_q == ADDR) || (state_q == DRIVE));
  assign bus.data_oe  = (state_q == DRIVE) || (state_q == HOLD);
  assign bus.done     = done_q;
  assign bus.addr_out = addr_q;
  assign bus.data_out = data_q;

endmodule
